// File: rtl/regfile_access_master_pkg.sv
// ---------------------------------------------------------------------------
// regfile_access_master_pkg
//
// Shared definitions for the register-file access master:
//   - FSM state encoding (ST_IDLE, ST_INIT)
//   - default register index / data widths
//   - response FIFO entry layout helpers
//
// Response FIFO entry layout, MSB first:
//   { is_write (only with RF_MASTER_WRITE_ACK_EN), addr[ADDR_W], data[DATA_W] }
//
// Configuration macro: RF_MASTER_WRITE_ACK_EN (adds the is_write flag bit).
// ---------------------------------------------------------------------------
package regfile_access_master_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    // Data sits in the low bits of an entry, the register index above it.
    function automatic int entry_data_lsb();
        return 0;
    endfunction

    function automatic int entry_addr_lsb(input int data_w);
        return data_w;
    endfunction

    // Total entry width; the write-acknowledge build carries one extra
    // flag bit at the top of each entry.
    function automatic int entry_width(input int addr_w, input int data_w);
`ifdef RF_MASTER_WRITE_ACK_EN
        return addr_w + data_w + 1;
`else
        return addr_w + data_w;
`endif
    endfunction

endpackage

// File: rtl/regfile_access_master_rsp_fifo.sv
// ---------------------------------------------------------------------------
// regfile_access_master_rsp_fifo
//
// Response FIFO for the register-file access master. Synchronous,
// single clock, power-of-two depth so the pointers wrap on their own.
//
// Parameters:
//   WIDTH  entry width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write wdata this cycle (ignored when full)
//   pop    in   drop the head entry this cycle (ignored when empty)
//   wdata  in   entry to store
//   rdata  out  head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
// ---------------------------------------------------------------------------
module regfile_access_master_rsp_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. A simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale contents are never presented because
    // the consumer qualifies the head with empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/regfile_access_master.sv
// ---------------------------------------------------------------------------
// regfile_access_master
//
// Initiator for the 32x32 register file. Drives the write port and read
// port 1 on behalf of a valid/ready command stream, returns read data on a
// buffered valid/ready response stream, and can sweep every register to
// INIT_VALUE (post-reset clearing / loader use).
//
// Parameters:
//   ADDR_W      register index width (2**ADDR_W registers swept by init)
//   DATA_W      register data width
//   RSP_DEPTH   response FIFO entries (power of two, >= 2)
//   INIT_VALUE  value written to every register by the sweep
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/addr/wdata      command payload (1 = write, 0 = read)
//   init_start                pulse to start the init sweep
//   init_busy                 sweep in progress
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_addr         head response entry
//   rsp_is_write              head entry is a write ack (macro builds only)
//   rf_read_reg/rf_read_data  register file read port 1
//   rf_write_reg/data/en      register file write port
//
// Configuration macro: RF_MASTER_WRITE_ACK_EN
//   defined   - accepted writes also queue {addr, wdata} with rsp_is_write=1
//   undefined - writes produce no response, rsp_is_write is absent
// ---------------------------------------------------------------------------
module regfile_access_master
    import regfile_access_master_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter int                RSP_DEPTH  = 2,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              init_start,
    output logic              init_busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
`ifdef RF_MASTER_WRITE_ACK_EN
    output logic              rsp_is_write,
`endif
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en
);

    localparam int                ENTRY_W  = entry_width(ADDR_W, DATA_W);
    localparam int                DATA_LSB = entry_data_lsb();
    localparam int                ADDR_LSB = entry_addr_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t                     state;
    state_t                     state_next;
    logic [ADDR_W-1:0]          sweep_idx;
    logic                       accept;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(RSP_DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head_entry;

    // State register and sweep index. The index runs only while sweeping
    // and naturally wraps back to zero after the last register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
            end else begin
                sweep_idx <= '0;
            end
        end
    end

    // Next state, handshake and register-file port muxing. Everything is
    // held quiet while rst is high so nothing is written on the reset edge.
    // The FIFO has no pass-through: a full FIFO blocks every command, and
    // init_start takes priority over a command presented in the same cycle.
    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        accept        = 1'b0;
        rf_read_reg   = '0;
        rf_write_en   = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    cmd_ready = !fifo_full && !init_start;
                    accept    = cmd_valid && cmd_ready;
                    if (init_start) begin
                        state_next = ST_INIT;
                    end
                    if (accept && cmd_write) begin
                        rf_write_en   = 1'b1;
                        rf_write_reg  = cmd_addr;
                        rf_write_data = cmd_wdata;
                    end
                    if (accept && !cmd_write) begin
                        rf_read_reg = cmd_addr;
                    end
                end
                ST_INIT: begin
                    rf_write_en   = 1'b1;
                    rf_write_reg  = sweep_idx;
                    rf_write_data = INIT_VALUE;
                    if (sweep_idx == LAST_IDX) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Reads capture the combinational register-file data at the accept
    // edge; write acks (when built in) capture the write data instead.
`ifdef RF_MASTER_WRITE_ACK_EN
    assign fifo_push  = accept;
    assign push_entry = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : rf_read_data};
`else
    assign fifo_push  = accept && !cmd_write;
    assign push_entry = {cmd_addr, rf_read_data};
`endif

    assign fifo_pop  = rsp_valid && rsp_ready;
    assign init_busy = (state == ST_INIT);
    assign rsp_valid = (fifo_count != '0);

    // Head fields are forced to zero when empty so the response outputs
    // read as zero after reset instead of showing stale storage.
    assign rsp_data = fifo_empty ? '0 : head_entry[DATA_LSB +: DATA_W];
    assign rsp_addr = fifo_empty ? '0 : head_entry[ADDR_LSB +: ADDR_W];
`ifdef RF_MASTER_WRITE_ACK_EN
    assign rsp_is_write = !fifo_empty && head_entry[ENTRY_W-1];
`endif

    regfile_access_master_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_regfile_access_master.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_master
//
// Self-checking bench for regfile_access_master. Holds a behavioural
// register file connected to the master's rf_* ports, plus a reference
// model (expected register contents, a queue of expected responses and a
// sweep countdown). Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_regfile_access_master;

    localparam int          ADDR_W     = 5;
    localparam int          DATA_W     = 32;
    localparam int          RSP_DEPTH  = 2;
    localparam int          NREG       = 32;
    localparam logic [31:0] INIT_VALUE = 32'h0;

    typedef struct {
        logic        is_write;
        logic [4:0]  addr;
        logic [31:0] data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              init_start;
    logic              init_busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
`ifdef RF_MASTER_WRITE_ACK_EN
    logic              rsp_is_write;
`endif
    logic [ADDR_W-1:0] rf_read_reg;
    logic [DATA_W-1:0] rf_read_data;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_en;

    logic [31:0] rf_mem [NREG];
    logic [31:0] exp_rf [NREG];
    rsp_t        exp_q [$];
    int          init_left;
    int          init_idx;
    bit          prev_rst;
    int          checks;
    int          passes;
    int          fails;

    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_write_en) begin
            rf_mem[rf_write_reg] <= rf_write_data;
        end
    end
    assign rf_read_data = rf_mem[rf_read_reg];

    regfile_access_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RSP_DEPTH  (RSP_DEPTH),
        .INIT_VALUE (INIT_VALUE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .init_start    (init_start),
        .init_busy     (init_busy),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_addr      (rsp_addr),
`ifdef RF_MASTER_WRITE_ACK_EN
        .rsp_is_write  (rsp_is_write),
`endif
        .rf_read_reg   (rf_read_reg),
        .rf_read_data  (rf_read_data),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_write_en   (rf_write_en)
    );

    // One comparison: counts it and reports a failure with tag and values.
    task automatic compare(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Called mid-cycle with inputs stable: checks outputs against the model,
    // then advances the model by the effects of the coming clock edge.
    task automatic checkOutput();
        logic exp_ready;
        logic exp_we;
        rsp_t head;
        exp_ready = !rst && (init_left == 0) && (exp_q.size() < RSP_DEPTH) && !init_start;
        exp_we    = !rst && ((init_left != 0) || (exp_ready && cmd_valid && cmd_write));
        compare("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        compare("rf_write_en", 32'(rf_write_en), 32'(exp_we));
        if (!rst) begin
            compare("init_busy", 32'(init_busy), 32'(init_left != 0));
            compare("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
            if (prev_rst) begin
                compare("reset_rsp_data", rsp_data, 32'h0);
                compare("reset_rsp_addr", 32'(rsp_addr), 32'h0);
            end
            if (init_left != 0) begin
                compare("sweep_reg", 32'(rf_write_reg), 32'(init_idx));
                compare("sweep_data", rf_write_data, INIT_VALUE);
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                compare("rsp_addr", 32'(rsp_addr), 32'(head.addr));
                compare("rsp_data", rsp_data, head.data);
`ifdef RF_MASTER_WRITE_ACK_EN
                compare("rsp_is_write", 32'(rsp_is_write), 32'(head.is_write));
`endif
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            if (init_left != 0) begin
                exp_rf[init_idx] = INIT_VALUE;
                init_idx++;
                init_left--;
            end else if (init_start) begin
                init_left = NREG;
                init_idx  = 0;
            end
            if (exp_ready && cmd_valid) begin
                if (cmd_write) begin
                    exp_rf[cmd_addr] = cmd_wdata;
`ifdef RF_MASTER_WRITE_ACK_EN
                    exp_q.push_back('{1'b1, cmd_addr, cmd_wdata});
`endif
                end else begin
                    exp_q.push_back('{1'b0, cmd_addr, exp_rf[cmd_addr]});
                end
            end
        end else begin
            exp_q.delete();
            init_left = 0;
            init_idx  = 0;
        end
        prev_rst = rst;
    endtask

    // Drives one cycle of inputs, checks at the falling edge, and returns
    // just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic start,
                                 input logic rr, input logic r);
        cmd_valid  = v;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = d;
        init_start = start;
        rsp_ready  = rr;
        rst        = r;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        fails      = 0;
        init_left  = 0;
        init_idx   = 0;
        prev_rst   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        init_start = 1'b0;
        rsp_ready  = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then fill every register with a random value.
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 1);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 1);
        for (int i = 0; i < NREG; i++) begin
            applyStimulus(1, 1, 5'(i), $urandom, 0, 1, 0);
        end

        // Write r5 then read it back the very next cycle.
        applyStimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, 1, 0);
        applyStimulus(1, 0, 5'd5, 32'h0, 0, 1, 0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);

        // Backpressure: two reads fill the FIFO, the third waits.
        applyStimulus(1, 0, 5'd1, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 5'd2, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 5'd3, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 5'd3, 32'h0, 0, 1, 0);
        applyStimulus(1, 0, 5'd3, 32'h0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
        end

        // Known pattern, then sweep; a write to r7 collides with the start.
        for (int i = 0; i < NREG; i++) begin
            applyStimulus(1, 1, 5'(i), 32'(i) * 32'h11111111, 0, 1, 0);
        end
        applyStimulus(1, 1, 5'd7, 32'h1, 1, 1, 0);
        for (int i = 0; i < NREG + 1; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
        end
        for (int i = 0; i < NREG; i++) begin
            applyStimulus(1, 0, 5'(i), 32'h0, 0, 1, 0);
        end
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);

`ifdef RF_MASTER_WRITE_ACK_EN
        // Write acknowledge for r3.
        applyStimulus(1, 1, 5'd3, 32'hA5, 0, 1, 0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
`endif

        // Randomized traffic with occasional sweeps.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, NREG - 1)), $urandom,
                          $urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0, 0);
        end
        for (int i = 0; i < NREG + 4; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
        end

        // Reset at sweep index 10 with two responses queued.
        for (int i = 11; i < NREG; i++) begin
            applyStimulus(1, 1, 5'(i), $urandom, 0, 1, 0);
        end
        applyStimulus(1, 0, 5'd11, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 5'd12, 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 5'd0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 0, 0, 0);
        end
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 0, 1);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
        for (int i = 11; i < NREG; i++) begin
            applyStimulus(1, 0, 5'(i), 32'h0, 0, 1, 0);
        end
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 1, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
